// File: rtl/spi_memory_master.sv
// Mode-0 SPI initiator for single-byte reads/writes against the SPI memory responder.
// Optional define SPI_MASTER_MISO_SYNC_EN adds a two-flop MISO synchronizer (needs CLK_DIV >= 3).
module spi_memory_master #(
    parameter int CLK_DIV    = 4,
    parameter int TURNAROUND = 2,
    parameter int CS_IDLE    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       cs_pin,
    output logic       sclk_pin,
    output logic       mosi_pin,
    input  logic       miso_pin
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
    localparam bit            HAS_GAP  = (TURNAROUND > 0);
    localparam logic [7:0]    GAP_LAST = 8'(TURNAROUND - 1);
    localparam logic [7:0]    IDL_LAST = 8'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, CMD, GAP, DATA, HOLD, CSWAIT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    cmd_sh, cmd_sh_n;
    logic [7:0]    data_sh, data_sh_n;
    logic          rw_q, rw_q_n;
    logic          sclk_n, mosi_n, cs_n, busy_n, done_n;
    logic [7:0]    rdata_n;
    logic          tc;
    logic          miso_cap;
    logic [CW-1:0] cap_at;

`ifdef SPI_MASTER_MISO_SYNC_EN
    generate
        if (CLK_DIV < 3) begin : g_div_check
            $error("spi_memory_master: CLK_DIV must be >= 3 with the MISO synchronizer");
        end
    endgenerate

    logic miso_s1, miso_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= miso_pin;
            miso_s2 <= miso_s1;
        end
    end

    // Synchronizer adds two cycles, so sample two cycles into the high phase.
    assign miso_cap = miso_s2;
    assign cap_at   = CW'(2);
`else
    assign miso_cap = miso_pin;
    assign cap_at   = '0;
`endif

    assign tc = (cnt == CNT_MAX);

    always_comb begin
        state_n   = state;
        cnt_n     = '0;
        bit_cnt_n = bit_cnt;
        cmd_sh_n  = cmd_sh;
        data_sh_n = data_sh;
        rw_q_n    = rw_q;
        sclk_n    = sclk_pin;
        mosi_n    = mosi_pin;
        cs_n      = cs_pin;
        busy_n    = busy;
        done_n    = 1'b0;
        rdata_n   = rdata;

        if (state != IDLE)
            cnt_n = tc ? '0 : cnt + 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = SETUP;
                    cmd_sh_n  = {addr, rw};
                    data_sh_n = wdata;
                    rw_q_n    = rw;
                    mosi_n    = addr[6];
                    cs_n      = 1'b0;
                    busy_n    = 1'b1;
                    bit_cnt_n = '0;
                end
            end
            SETUP: begin
                if (tc) begin
                    state_n = CMD;
                    sclk_n  = 1'b1;
                end
            end
            CMD: begin
                if (tc) begin
                    if (!sclk_pin) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n    = 1'b0;
                        cmd_sh_n  = {cmd_sh[6:0], 1'b0};
                        mosi_n    = cmd_sh[6];
                        bit_cnt_n = bit_cnt + 8'd1;
                        if (bit_cnt == 8'd7) begin
                            bit_cnt_n = '0;
                            if (rw_q && HAS_GAP) begin
                                state_n = GAP;
                                mosi_n  = 1'b0;
                            end else begin
                                state_n = DATA;
                                mosi_n  = rw_q ? 1'b0 : data_sh[7];
                            end
                        end
                    end
                end
            end
            GAP: begin
                if (tc) begin
                    if (!sclk_pin) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n    = 1'b0;
                        bit_cnt_n = bit_cnt + 8'd1;
                        if (bit_cnt == GAP_LAST) begin
                            bit_cnt_n = '0;
                            state_n   = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (rw_q && sclk_pin && cnt == cap_at)
                    data_sh_n = {data_sh[6:0], miso_cap};
                if (tc) begin
                    if (!sclk_pin) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n    = 1'b0;
                        bit_cnt_n = bit_cnt + 8'd1;
                        if (!rw_q) begin
                            data_sh_n = {data_sh[6:0], 1'b0};
                            mosi_n    = data_sh[6];
                        end
                        if (bit_cnt == 8'd7) begin
                            bit_cnt_n = '0;
                            state_n   = HOLD;
                            mosi_n    = 1'b0;
                        end
                    end
                end
            end
            HOLD: begin
                if (tc) begin
                    state_n = CSWAIT;
                    cs_n    = 1'b1;
                    done_n  = 1'b1;
                    if (rw_q)
                        rdata_n = data_sh;
                end
            end
            CSWAIT: begin
                if (tc) begin
                    bit_cnt_n = bit_cnt + 8'd1;
                    if (bit_cnt == IDL_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = IDLE;
                        busy_n    = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cs_n    = 1'b1;
                sclk_n  = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            cmd_sh   <= '0;
            data_sh  <= '0;
            rw_q     <= 1'b0;
            sclk_pin <= 1'b0;
            mosi_pin <= 1'b0;
            cs_pin   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_cnt  <= bit_cnt_n;
            cmd_sh   <= cmd_sh_n;
            data_sh  <= data_sh_n;
            rw_q     <= rw_q_n;
            sclk_pin <= sclk_n;
            mosi_pin <= mosi_n;
            cs_pin   <= cs_n;
            busy     <= busy_n;
            done     <= done_n;
            rdata    <= rdata_n;
        end
    end

endmodule

// File: tb/tb_spi_memory_master.sv
// Directed bench for spi_memory_master: CLK_DIV=2 instance with a responder model,
// plus a CLK_DIV=1 instance for back-to-back frame spacing.
module tb_spi_memory_master;

    localparam int D   = 2;
    localparam int TA  = 2;
    localparam int CSI = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, cs_pin, sclk_pin, mosi_pin, miso;
    logic [7:0] rdata;

    logic       start1 = 1'b0;
    logic       miso1 = 1'b0;
    logic       busy1, done1, cs1, sclk1, mosi1;
    logic [7:0] rdata1;

    always #5 clk = ~clk;

    spi_memory_master #(.CLK_DIV(D), .TURNAROUND(TA), .CS_IDLE(CSI)) dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .cs_pin(cs_pin), .sclk_pin(sclk_pin),
        .mosi_pin(mosi_pin), .miso_pin(miso)
    );

    spi_memory_master #(.CLK_DIV(1), .TURNAROUND(TA), .CS_IDLE(CSI)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .rw(1'b0), .addr(7'h33), .wdata(8'hC3),
        .busy(busy1), .done(done1), .rdata(rdata1), .cs_pin(cs1), .sclk_pin(sclk1),
        .mosi_pin(mosi1), .miso_pin(miso1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder model: records MOSI on each SPI rise, drives resp on MISO during the data byte.
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    logic [31:0] mosi_bits = '0;
    logic [7:0]  resp = '0;

    always @(negedge cs_pin) begin
        rise_cnt  = 0;
        fall_cnt  = 0;
        mosi_bits = '0;
    end
    always @(posedge sclk_pin) begin
        rise_cnt++;
        mosi_bits = {mosi_bits[30:0], mosi_pin};
    end
    always @(negedge sclk_pin) fall_cnt++;

    always_comb begin
        miso = 1'b0;
        if (fall_cnt >= 8 + TA && fall_cnt < 16 + TA)
            miso = resp[15 + TA - fall_cnt];
    end

    int rises1 = 0;
    always @(negedge cs1) rises1 = 0;
    always @(posedge sclk1) rises1++;

    int passed = 0;
    int total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int         done_at, busy_low, done_cnt, timed_out;
    logic [7:0] rdata_at_done;
    logic       cs_at1, busy_at1;

    task automatic run_frame(input logic f_rw, input logic [6:0] f_addr, input logic [7:0] f_wdata,
                             input logic [7:0] f_resp, input int extra_at, input int rst_at);
        int t0;
        int n;
        resp      = f_resp;
        done_cnt  = 0;
        done_at   = -1;
        busy_low  = -1;
        timed_out = 1;
        @(negedge clk);
        start = 1'b1;
        rw    = f_rw;
        addr  = f_addr;
        wdata = f_wdata;
        t0    = cyc;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n = cyc - t0;
            if (n == 1) begin
                start    = 1'b0;
                cs_at1   = cs_pin;
                busy_at1 = busy;
            end
            if (n == extra_at) begin
                start = 1'b1;
                rw    = ~f_rw;
                addr  = ~f_addr;
                wdata = ~f_wdata;
            end
            if (n == extra_at + 1) start = 1'b0;
            if (done) begin
                done_cnt++;
                done_at       = n;
                rdata_at_done = rdata;
            end
            if (n == rst_at) begin
                check("pre_rst_sclk", sclk_pin, 1);
                check("pre_rst_cs", cs_pin, 0);
                #1 reset = 1'b1;
                #1;
                check("rst_cs_async", cs_pin, 1);
                check("rst_sclk_async", sclk_pin, 0);
                repeat (3) begin
                    @(negedge clk);
                    if (done) done_cnt++;
                end
                check("rst_no_done", done_cnt, 0);
                check("rst_rdata", rdata, 0);
                check("rst_busy", busy, 0);
                reset     = 1'b0;
                timed_out = 0;
                break;
            end
            if (n > 1 && !busy) begin
                busy_low  = n;
                timed_out = 0;
                break;
            end
        end
        check("frame_timeout", timed_out, 0);
    endtask

    initial begin
        int hi_run, lo_run, frames, d1;
        logic prev;

        repeat (3) @(negedge clk);
        check("rst_cs", cs_pin, 1);
        check("rst_sclk", sclk_pin, 0);
        check("rst_mosi", mosi_pin, 0);
        check("rst_busy0", busy, 0);
        check("rst_done0", done, 0);
        check("rst_rdata0", rdata, 0);
        reset = 1'b0;

        // Write 0x15 <- 0xA5
        run_frame(1'b0, 7'h15, 8'hA5, 8'h00, -1, -1);
        check("wr_cs_low_c1", cs_at1, 0);
        check("wr_busy_c1", busy_at1, 1);
        check("wr_mosi", mosi_bits, 32'h0000_2AA5);
        check("wr_rises", rise_cnt, 16);
        check("wr_done_at", done_at, 67);
        check("wr_busy_low", busy_low, 71);
        check("wr_done_cnt", done_cnt, 1);
        check("wr_rdata", rdata, 8'h00);

        // Read 0x7F -> 0x3C
        run_frame(1'b1, 7'h7F, 8'h00, 8'h3C, -1, -1);
        check("rd_mosi", mosi_bits, 32'h0003_FC00);
        check("rd_rises", rise_cnt, 18);
        check("rd_done_at", done_at, 75);
        check("rd_busy_low", busy_low, 79);
        check("rd_rdata_at_done", rdata_at_done, 8'h3C);
        check("rd_rdata", rdata, 8'h3C);

        // Write with a stray start mid-frame
        run_frame(1'b0, 7'h01, 8'h5A, 8'h00, 10, -1);
        check("ign_mosi", mosi_bits, 32'h0000_025A);
        check("ign_rises", rise_cnt, 16);
        check("ign_done_cnt", done_cnt, 1);
        check("ign_done_at", done_at, 67);
        check("ign_rdata", rdata, 8'h3C);
        repeat (4) @(negedge clk);
        check("ign_no_2nd_frame", busy, 0);

        // Reset in the middle of a read, then a full read
        run_frame(1'b1, 7'h40, 8'h00, 8'hFF, -1, 20);
        run_frame(1'b1, 7'h2B, 8'h00, 8'h81, -1, -1);
        check("rd2_mosi", mosi_bits, 32'h0001_5C00);
        check("rd2_done_at", done_at, 75);
        check("rd2_rdata", rdata, 8'h81);
        check("rd2_done_cnt", done_cnt, 1);

        // CLK_DIV=1 back-to-back writes with start held high
        hi_run = 0;
        lo_run = 0;
        frames = 0;
        d1     = 0;
        prev   = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        for (int i = 0; i < 300 && frames < 3; i++) begin
            @(negedge clk);
            if (done1) d1++;
            if (cs1 && !prev) begin
                check("d1_cs_low", lo_run, 33);
                check("d1_rises", rises1, 16);
                frames++;
                hi_run = 1;
            end else if (!cs1 && prev) begin
                if (frames > 0) check("d1_cs_high", hi_run, 3);
                lo_run = 1;
            end else if (cs1) begin
                hi_run++;
            end else begin
                lo_run++;
            end
            prev = cs1;
        end
        start1 = 1'b0;
        check("d1_frames", frames, 3);
        check("d1_done", d1, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_memory_master.md
# spi_memory_master

SPI initiator that runs single-byte read and write transactions against the team's SPI memory responder. It converts a one-cycle `start` request with address, direction and write data into a mode-0 SPI frame on the chip-select, clock, MOSI and MISO pins, and returns read data with a `done` pulse. It sits between the system-side controller logic and the off-block SPI memory.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SPI half-period (≥1); one SPI bit takes 2·`CLK_DIV` clk cycles.
- `TURNAROUND`, 2: dummy SPI clock pulses between the command byte and read data; reads only.
- `CS_IDLE`, 2: minimum `cs_pin`-high time after a frame, in SPI half-periods (≥1).
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request pulse; accepted only when `busy`=0.
- `rw` input 1: 1=read, 0=write; sampled when `start` is accepted.
- `addr` input 7: memory address; sampled when `start` is accepted.
- `wdata` input 8: write data; sampled when `start` is accepted.
- `busy` output 1: high from the cycle after acceptance until the CS idle time ends.
- `done` output 1: one-cycle pulse on the cycle `cs_pin` returns high.
- `rdata` output 8: last read byte; holds its value until the next read completes.
- `cs_pin` output 1: chip select, active low.
- `sclk_pin` output 1: SPI clock; idles low.
- `mosi_pin` output 1: master-out data.
- `miso_pin` input 1: master-in data.

## Operation
- Reset values: `cs_pin`=1, `sclk_pin`=0, `mosi_pin`=0, `busy`=0, `done`=0, `rdata`=0. The FSM returns to IDLE.
- Command byte is {`addr`[6:0], `rw`}, sent MSB first, so the direction bit is the 8th bit the responder samples.
- States:
  - IDLE: on `start`, latch the inputs and go to SETUP.
  - SETUP: `cs_pin` low, `mosi_pin` = command bit 7, for one half-period.
  - CMD: 8 SPI clocks. Then go to GAP if read with `TURNAROUND`>0, DATA otherwise.
  - GAP: `TURNAROUND` clocks with `mosi_pin`=0.
  - DATA: 8 SPI clocks. On writes, MOSI carries `wdata` MSB first. On reads, MOSI=0 and MISO is shifted in MSB first.
  - HOLD: one half-period with `sclk_pin` low, then raise `cs_pin`, pulse `done`, and load `rdata` on reads.
  - CSWAIT: `CS_IDLE` half-periods, then go to IDLE with `busy`=0.
- MOSI changes only on the clk cycle `sclk_pin` falls, or on SETUP entry. MISO is captured on the clk cycle `sclk_pin` rises.
- A half-period counter counts 0..`CLK_DIV`-1. At terminal count, `sclk_pin` toggles in CMD/GAP/DATA or the state advances.
- `start` while `busy`=1 is ignored. Inputs are not re-sampled mid-frame.
- Asserting `reset` mid-frame aborts immediately: `cs_pin` goes high asynchronously and no `done` is issued.
- A write leaves `rdata` unchanged.

## Timing
- With `start` accepted at cycle 0 and D=`CLK_DIV`:
  - `cs_pin` falls and `busy` rises at cycle 1.
  - SPI rising edges occur at 1+(2k+1)·D; falling edges at 1+(2k+2)·D.
- Write: 16 SPI clocks. The last fall is at 1+32D; `cs_pin` rises and `done` pulses at 1+33D.
- Read: adds 2·`TURNAROUND`·D, so `done` is at 1+(33+2·`TURNAROUND`)·D. `rdata` is valid in the same cycle as `done`.
- `busy` falls at `done` cycle + `CS_IDLE`·D. A new `start` is accepted on that cycle.
- Back-to-back throughput is therefore one transaction per (33+`CS_IDLE`)·D+1 cycles (writes).

## Configuration
- `SPI_MASTER_MISO_SYNC_EN` defined:
  - `miso_pin` passes through a two-flop synchronizer (reset to 0).
  - MISO is captured 2 clk cycles after the rising edge of `sclk_pin`.
  - `CLK_DIV` must be ≥3; otherwise elaboration fails via `$error`.
- Undefined: MISO is sampled directly on the rising-edge cycle, and `CLK_DIV`≥1 is allowed.

## Test plan
- Write, D=2, `addr`=0x15, `rw`=0, `wdata`=0xA5 → MOSI at the 16 rising edges is 0,0,1,0,1,0,1,0 then 1,0,1,0,0,1,0,1. `done` at cycle 67, `busy` low at cycle 71, `rdata` stays 0.
- Read, D=2, `TURNAROUND`=2, `addr`=0x7F, responder model drives 0x3C on MISO during DATA → command bits 1111111,1. `done` at cycle 75 with `rdata`=0x3C.
- `start` pulsed at cycle 10 of an active write → ignored: exactly one frame and one `done`, and the latched `wdata` is unchanged.
- `reset` asserted at cycle 20 of a read → `cs_pin`=1 and `sclk_pin`=0 within the same cycle, no `done`. The next `start` after release runs a full correct frame.
- D=1, back-to-back writes with `start` held high → `cs_pin` is high for ≥`CS_IDLE` cycles between frames, and each frame is 16 clocks wide.
- With `SPI_MASTER_MISO_SYNC_EN`, D=3, read 0x81 → `rdata`=0x81.
